hazard_ctrl: RTL and testbench

//  Pipeline control for the 5-stage core; consumes the ID/EX register outputs plus ID-stage operand addresses.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Port bundle between the pipeline datapath and hazard_ctrl: EX/ID hazard sources,
// data-memory handshake, and the stall/flush controls sent back to the pipeline registers.
interface hazard_ctrl_if;
    logic       MemRead_ex;
    logic [4:0] rdAddr_ex;
    logic [4:0] rs1Addr_id;
    logic [4:0] rs2Addr_id;
    logic       rs1Used_id;
    logic       rs2Used_id;
    logic       Redirect_ex;
    logic       mem_req;
    logic       mem_ready;
    logic       PC_stall;
    logic       IF_ID_stall;
    logic       IF_ID_flush;
    logic       ID_EX_stall;
    logic       ID_EX_flush;
    logic       EX_MEM_stall;
    logic       MEM_WB_flush;
    logic       mem_timeout;

    // Datapath side: supplies hazard sources, consumes the controls.
    modport master (
        output MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
               Redirect_ex, mem_req, mem_ready,
        input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall,
               MEM_WB_flush, mem_timeout
    );

    // Hazard controller side.
    modport slave (
        input  MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
               Redirect_ex, mem_req, mem_ready,
        output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall,
               MEM_WB_flush, mem_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush control for the 5-stage core: load-use, EX redirect and data-memory wait with a
// sticky timeout. Define HAZARD_PERF_EN to add saturating hazard performance counters.
module hazard_ctrl #(
    parameter int unsigned TO_W     = 5,
    parameter int unsigned TO_LIMIT = 20
) (
    input  logic         clk,
    input  logic         Reset,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]  perf_lu_cnt,
    output logic [31:0]  perf_mw_cnt,
    output logic [31:0]  perf_fl_cnt
`endif
);

    typedef enum logic [0:0] {StRun, StWait} state_e;

    localparam logic [TO_W-1:0] Limit = TO_W'(TO_LIMIT);
    localparam logic [TO_W-1:0] One   = TO_W'(1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            timeout_hit;
    logic            memwait;
    logic            loaduse;
    logic            rs1_hit, rs2_hit;

    assign memwait = bus.mem_req & ~bus.mem_ready;
    assign rs1_hit = bus.rs1Used_id & (bus.rs1Addr_id == bus.rdAddr_ex);
    assign rs2_hit = bus.rs2Used_id & (bus.rs2Addr_id == bus.rdAddr_ex);
    assign loaduse = bus.MemRead_ex & (bus.rdAddr_ex != 5'd0) & (rs1_hit | rs2_hit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (memwait) begin
                    state_d = StWait;
                    cnt_d   = One;
                end
            end
            StWait: begin
                if (memwait) begin
                    cnt_d = (cnt_q == Limit) ? cnt_q : cnt_q + One;
                end else begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
        if (Reset) begin
            state_d = StRun;
            cnt_d   = '0;
        end
    end

    // The flag is visible in the very cycle the counter reaches the limit, then held.
    assign timeout_hit     = ~Reset & (cnt_d == Limit);
    assign timeout_d       = ~Reset & (timeout_q | timeout_hit);
    assign bus.mem_timeout = ~Reset & (timeout_q | timeout_hit);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        bus.PC_stall     = 1'b0;
        bus.IF_ID_stall  = 1'b0;
        bus.IF_ID_flush  = 1'b0;
        bus.ID_EX_stall  = 1'b0;
        bus.ID_EX_flush  = 1'b0;
        bus.EX_MEM_stall = 1'b0;
        bus.MEM_WB_flush = 1'b0;
        if (Reset) begin
            // everything held low
        end else if (memwait) begin
            bus.PC_stall     = 1'b1;
            bus.IF_ID_stall  = 1'b1;
            bus.ID_EX_stall  = 1'b1;
            bus.EX_MEM_stall = 1'b1;
            bus.MEM_WB_flush = 1'b1;
        end else if (bus.Redirect_ex) begin
            // The ID instruction is discarded, so any load-use on it is moot.
            bus.IF_ID_flush = 1'b1;
            bus.ID_EX_flush = 1'b1;
        end else if (loaduse) begin
            bus.PC_stall    = 1'b1;
            bus.IF_ID_stall = 1'b1;
            bus.ID_EX_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (Reset) begin
            perf_lu_cnt <= '0;
            perf_mw_cnt <= '0;
            perf_fl_cnt <= '0;
        end else begin
            if (memwait && (perf_mw_cnt != '1)) begin
                perf_mw_cnt <= perf_mw_cnt + 32'd1;
            end
            if (!memwait && bus.Redirect_ex && (perf_fl_cnt != '1)) begin
                perf_fl_cnt <= perf_fl_cnt + 32'd1;
            end
            if (!memwait && !bus.Redirect_ex && loaduse && (perf_lu_cnt != '1)) begin
                perf_lu_cnt <= perf_lu_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int TO_LIMIT = 20;

    logic clk;
    logic Reset;
    int   n_cmp = 0;
    int   n_err = 0;

    hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_mw_cnt, perf_fl_cnt;
`endif

    hazard_ctrl #(
        .TO_W     (5),
        .TO_LIMIT (TO_LIMIT)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .bus         (hz.slave)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_cnt (perf_lu_cnt),
        .perf_mw_cnt (perf_mw_cnt),
        .perf_fl_cnt (perf_fl_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: length of the current unbroken memory-wait run, sticky timeout, perf tallies.
    int m_run    = 0;
    bit m_sticky = 1'b0;
    int m_lu     = 0;
    int m_mw     = 0;
    int m_fl     = 0;

    function automatic bit f_memwait();
        return hz.mem_req && !hz.mem_ready;
    endfunction

    function automatic bit f_loaduse();
        bit hit1, hit2;
        hit1 = hz.rs1Used_id && (hz.rs1Addr_id == hz.rdAddr_ex);
        hit2 = hz.rs2Used_id && (hz.rs2Addr_id == hz.rdAddr_ex);
        return hz.MemRead_ex && (hz.rdAddr_ex != 5'd0) && (hit1 || hit2);
    endfunction

    // Bits: PC_stall IF_ID_stall IF_ID_flush ID_EX_stall ID_EX_flush EX_MEM_stall MEM_WB_flush timeout
    function automatic logic [7:0] model_out();
        logic [7:0] e;
        e = '0;
        if (Reset) return e;
        if (f_memwait())         e[7:1] = 7'b1101011;
        else if (hz.Redirect_ex) e[7:1] = 7'b0010100;
        else if (f_loaduse())    e[7:1] = 7'b1100100;
        e[0] = m_sticky || (f_memwait() && (m_run + 1 >= TO_LIMIT));
        return e;
    endfunction

    function automatic logic [7:0] act_vec();
        return {hz.PC_stall, hz.IF_ID_stall, hz.IF_ID_flush, hz.ID_EX_stall, hz.ID_EX_flush,
                hz.EX_MEM_stall, hz.MEM_WB_flush, hz.mem_timeout};
    endfunction

    always @(posedge clk) begin
        if (Reset) begin
            m_run    <= 0;
            m_sticky <= 1'b0;
            m_lu     <= 0;
            m_mw     <= 0;
            m_fl     <= 0;
        end else if (f_memwait()) begin
            m_run    <= m_run + 1;
            m_sticky <= m_sticky || (m_run + 1 >= TO_LIMIT);
            m_mw     <= m_mw + 1;
        end else begin
            m_run <= 0;
            if (hz.Redirect_ex)   m_fl <= m_fl + 1;
            else if (f_loaduse()) m_lu <= m_lu + 1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e, a;
        e = model_out();
        a = act_vec();
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL model_cycle t=%0t got=%b want=%b", $time, a, e);
        end
`ifdef HAZARD_PERF_EN
        n_cmp++;
        if (perf_lu_cnt !== 32'(m_lu) || perf_mw_cnt !== 32'(m_mw) || perf_fl_cnt !== 32'(m_fl)) begin
            n_err++;
            $display("FAIL model_perf t=%0t got=%0d/%0d/%0d want=%0d/%0d/%0d", $time,
                     perf_lu_cnt, perf_mw_cnt, perf_fl_cnt, m_lu, m_mw, m_fl);
        end
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] exp);
        @(negedge clk);
        n_cmp++;
        if (act_vec() !== exp) begin
            n_err++;
            $display("FAIL %s got=%b want=%b", name, act_vec(), exp);
        end
    endtask

    task automatic idle();
        hz.MemRead_ex  = 1'b0;
        hz.rdAddr_ex   = 5'd0;
        hz.rs1Addr_id  = 5'd0;
        hz.rs2Addr_id  = 5'd0;
        hz.rs1Used_id  = 1'b0;
        hz.rs2Used_id  = 1'b0;
        hz.Redirect_ex = 1'b0;
        hz.mem_req     = 1'b0;
        hz.mem_ready   = 1'b0;
    endtask

    task automatic set_t1();
        idle();
        hz.MemRead_ex = 1'b1;
        hz.rdAddr_ex  = 5'd5;
        hz.rs2Used_id = 1'b1;
        hz.rs2Addr_id = 5'd5;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pend;
        bit fin;
        Reset = 1'b1;
        idle();
        hz.mem_req = 1'b1;  // memwait during Reset must not leak out
        tick();
        chk("reset_outputs", 8'b0000_0000);
        tick();
        idle();
        Reset = 1'b0;
        chk("idle_after_reset", 8'b0000_0000);

        // T1: one-cycle load-use
        tick(); set_t1();
        chk("t1_loaduse", 8'b1100_1000);
        tick(); idle();
        chk("t1_release", 8'b0000_0000);
        // T2: x0 destination and unused-source cases
        tick(); set_t1(); hz.rdAddr_ex = 5'd0;
        chk("t2_rd_zero", 8'b0000_0000);
        tick(); set_t1(); hz.rs2Used_id = 1'b0; hz.rs1Used_id = 1'b0; hz.rs1Addr_id = 5'd5;
        chk("t2_rs1_unused", 8'b0000_0000);
        // T3: redirect beats load-use
        tick(); set_t1(); hz.Redirect_ex = 1'b1;
        chk("t3_redirect_over_lu", 8'b0010_1000);
        // T4: 3 wait cycles, released when ready
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); hz.mem_req = 1'b1;
            chk($sformatf("t4_wait%0d", i), 8'b1101_0110);
        end
        tick(); hz.mem_ready = 1'b1;
        chk("t4_ready_release", 8'b0000_0000);
        tick(); idle();
        chk("t4_back_idle", 8'b0000_0000);
`ifdef HAZARD_PERF_EN
        @(negedge clk);
        n_cmp++;
        if (perf_lu_cnt !== 32'd1 || perf_fl_cnt !== 32'd1 || perf_mw_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL t6_perf got=%0d/%0d/%0d want=1/3/1", perf_lu_cnt, perf_mw_cnt,
                     perf_fl_cnt);
        end
`endif
        // T5: 25-cycle wait, timeout from the 20th wait cycle, memwait beats redirect
        for (int i = 1; i <= 25; i++) begin
            tick(); idle(); hz.mem_req = 1'b1; hz.Redirect_ex = (i % 2 == 0);
            chk($sformatf("t5_wait%0d", i), (i >= TO_LIMIT) ? 8'b1101_0111 : 8'b1101_0110);
        end
        tick(); hz.mem_ready = 1'b1; hz.Redirect_ex = 1'b1;
        chk("t5_ready_redirect_sticky", 8'b0010_1001);
        tick(); idle();
        chk("t5_sticky_held", 8'b0000_0001);
        tick(); Reset = 1'b1; hz.mem_req = 1'b1;
        chk("t5_reset", 8'b0000_0000);
        tick(); Reset = 1'b0;
        chk("t5_reset_clears_restart", 8'b1101_0110);
        tick(); hz.mem_ready = 1'b1;
        chk("t5_run_again", 8'b0000_0000);

        // Randomized run; waits keep mem_req high until the ready cycle.
        pend = 0;
        fin  = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            hz.MemRead_ex  = ($urandom_range(0, 2) == 0);
            hz.rdAddr_ex   = 5'($urandom_range(0, 3));
            hz.rs1Addr_id  = 5'($urandom_range(0, 3));
            hz.rs2Addr_id  = 5'($urandom_range(0, 3));
            hz.rs1Used_id  = 1'($urandom_range(0, 1));
            hz.rs2Used_id  = 1'($urandom_range(0, 1));
            hz.Redirect_ex = ($urandom_range(0, 3) == 0);
            Reset          = ($urandom_range(0, 249) == 0);
            if (pend > 0) begin
                hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
                pend--;
                fin = (pend == 0);
            end else if (fin) begin
                hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
                fin = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                pend = ($urandom_range(0, 7) == 0) ? $urandom_range(18, 30) : $urandom_range(1, 4);
                hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
                pend--;
                fin = (pend == 0);
            end else begin
                hz.mem_req   = 1'(($urandom_range(0, 2) == 0));
                hz.mem_ready = hz.mem_req;
            end
        end
        tick(); idle(); Reset = 1'b0;
        @(negedge clk);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
